// File: rtl/tms_prog_mem_arbiter_if.sv
// Bus bundle for the program-memory arbiter: core fetch port, Wishbone slave
// port and the single-port SRAM macro port.
interface tms_prog_mem_arbiter_if;
    logic        fetch_req;
    logic [10:0] fetch_addr;
    logic        fetch_valid;
    logic [7:0]  fetch_data;

    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_o;
    logic        wbs_ack_o;

    logic        mem_csb;
    logic        mem_web;
    logic [3:0]  mem_wmask;
    logic [8:0]  mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    modport slave (
        input  fetch_req, fetch_addr,
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i, wbs_sel_i,
        input  mem_dout,
        output fetch_valid, fetch_data,
        output wbs_dat_o, wbs_ack_o,
        output mem_csb, mem_web, mem_wmask, mem_addr, mem_din
    );

    modport master (
        output fetch_req, fetch_addr,
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i, wbs_sel_i,
        output mem_dout,
        input  fetch_valid, fetch_data,
        input  wbs_dat_o, wbs_ack_o,
        input  mem_csb, mem_web, mem_wmask, mem_addr, mem_din
    );
endinterface

// File: rtl/tms_prog_mem_arbiter.sv
// Shares one 512x32 single-port program SRAM between the TMS1x00 byte fetch
// and the Wishbone loader; the core has priority, bounded by a starvation count.
module tms_prog_mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_n,
    tms_prog_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        C_DATA  = 2'd1,
        W_RDATA = 2'd2,
        W_ACK   = 2'd3
    } state_t;

    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    state_t      state;
    logic        fetch_pend;
    logic [10:0] faddr;
    logic [1:0]  lane;
    logic [2:0]  starve_cnt;

    logic        fetch_want;
    logic [10:0] fetch_a;
    logic        wb_pend;
    logic        core_win;
    logic        wb_win;
    logic        unused_adr_bits;

    assign unused_adr_bits = ^{bus.wbs_adr_i[31:17], bus.wbs_adr_i[15:11], bus.wbs_adr_i[1:0]};

    // A fetch_req seen in IDLE is served in the same cycle, so an uncontended
    // fetch completes in two cycles; otherwise it waits in the fetch latch.
    always_comb begin
        fetch_want = fetch_pend | bus.fetch_req;
        fetch_a    = fetch_pend ? faddr : bus.fetch_addr;
        wb_pend    = bus.wbs_cyc_i & bus.wbs_stb_i & bus.wbs_adr_i[16];
        core_win   = (state == IDLE) & fetch_want & (~wb_pend | (starve_cnt < LIMIT));
        wb_win     = (state == IDLE) & ~core_win & wb_pend;
    end

    always_comb begin
        bus.mem_csb   = 1'b1;
        bus.mem_web   = 1'b1;
        bus.mem_wmask = 4'b0000;
        bus.mem_addr  = 9'd0;
        bus.mem_din   = 32'd0;
        if (core_win) begin
            bus.mem_csb  = 1'b0;
            bus.mem_addr = fetch_a[10:2];
        end else if (wb_win) begin
            bus.mem_csb  = 1'b0;
            bus.mem_addr = bus.wbs_adr_i[10:2];
            if (bus.wbs_we_i) begin
                bus.mem_web   = 1'b0;
                bus.mem_wmask = bus.wbs_sel_i;
                bus.mem_din   = bus.wbs_dat_i;
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state           <= IDLE;
            fetch_pend      <= 1'b0;
            faddr           <= 11'd0;
            lane            <= 2'd0;
            starve_cnt      <= 3'd0;
            bus.fetch_valid <= 1'b0;
            bus.fetch_data  <= 8'd0;
            bus.wbs_ack_o   <= 1'b0;
            bus.wbs_dat_o   <= 32'd0;
        end else begin
            bus.fetch_valid <= 1'b0;
            bus.wbs_ack_o   <= 1'b0;

            // The first request to arrive owns the latch until it is served.
            if (core_win) begin
                fetch_pend <= 1'b0;
            end else if (bus.fetch_req && !fetch_pend) begin
                fetch_pend <= 1'b1;
                faddr      <= bus.fetch_addr;
            end

            case (state)
                IDLE: begin
                    if (core_win) begin
                        lane  <= fetch_a[1:0];
                        state <= C_DATA;
                        // core_win under contention implies starve_cnt < LIMIT
                        if (wb_pend) starve_cnt <= starve_cnt + 3'd1;
                    end else if (wb_win) begin
                        starve_cnt <= 3'd0;
                        if (bus.wbs_we_i) begin
                            state         <= W_ACK;
                            bus.wbs_ack_o <= 1'b1;
                        end else begin
                            state <= W_RDATA;
                        end
                    end
                end
                C_DATA: begin
                    bus.fetch_valid <= 1'b1;
                    case (lane)
                        2'd0:    bus.fetch_data <= bus.mem_dout[7:0];
                        2'd1:    bus.fetch_data <= bus.mem_dout[15:8];
                        2'd2:    bus.fetch_data <= bus.mem_dout[23:16];
                        default: bus.fetch_data <= bus.mem_dout[31:24];
                    endcase
                    state <= IDLE;
                end
                W_RDATA: begin
                    bus.wbs_dat_o <= bus.mem_dout;
                    bus.wbs_ack_o <= 1'b1;
                    state         <= W_ACK;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/tms_prog_mem_arbiter.md
# tms_prog_mem_arbiter

Arbitrates one single-port 512x32 program SRAM between the TMS1x00 core's byte-wide instruction fetch and the Wishbone loader/debug port. The core normally has priority. A starvation counter guarantees Wishbone progress. This block replaces the separate fetch and Wishbone ports in the TMS1x00 wrapper, so the program memory can use a single-port macro.

## Interface
Parameters:
- STARVE_LIMIT, default 4: consecutive core grants allowed while a Wishbone request waits. Must be at least 1. The counter is 3 bits wide, so the maximum value is 7.

Ports:
- wb_clk_i  in  1  the only clock; everything is on its rising edge.
- wb_rst_n  in  1  reset, asynchronous and active-low.
- fetch_req  in  1  single-cycle pulse that starts one fetch.
- fetch_addr  in  11  byte address; sampled on the cycle fetch_req is high.
- fetch_valid  out  1  one-cycle pulse when fetch_data is updated.
- fetch_data  out  8  fetched byte; holds until the next fetch_valid.
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone classic control.
- wbs_adr_i  in  32  bit 16 selects this block; bits [10:2] are the word address.
- wbs_dat_i  in  32  write data.
- wbs_sel_i  in  4  byte-lane enables for writes.
- wbs_dat_o  out  32  read data, valid while wbs_ack_o is high.
- wbs_ack_o  out  1  one-cycle acknowledge.
- mem_csb  out  1  SRAM chip select, active-low.
- mem_web  out  1  SRAM write enable, active-low.
- mem_wmask  out  4  SRAM byte write mask.
- mem_addr  out  9  SRAM word address.
- mem_din  out  32  SRAM write data.
- mem_dout  in  32  SRAM read data, valid the cycle after a read is issued.

## Operation
- **Fetch latch.** fetch_req sets fetch_pend and captures fetch_addr into faddr.
  - A fetch_req that arrives while fetch_pend=1 is ignored; faddr is not overwritten.
- **Wishbone pending.** wb_pend = wbs_cyc_i & wbs_stb_i & wbs_adr_i[16], evaluated only in IDLE.
  - A request with adr[16]=0 is never acknowledged by this block.
- **States.**
  - IDLE: arbitrates and drives the SRAM port combinationally.
  - C_DATA: returns the fetched byte.
  - W_RDATA: captures Wishbone read data.
  - W_ACK: acknowledges the Wishbone cycle.
- **IDLE arbitration.**
  - Core wins if fetch_pend & (~wb_pend | starve_cnt < STARVE_LIMIT).
    - Issue: mem_csb=0, mem_web=1, mem_addr=faddr[10:2].
    - Clear fetch_pend; go to C_DATA.
    - If wb_pend, starve_cnt increments, saturating at STARVE_LIMIT.
  - Otherwise, if wb_pend, Wishbone wins and starve_cnt clears.
    - Common: mem_csb=0, mem_addr=wbs_adr_i[10:2].
    - Write: mem_web=0, mem_wmask=wbs_sel_i, mem_din=wbs_dat_i; go to W_ACK.
    - Read: mem_web=1; go to W_RDATA.
  - Otherwise, mem_csb=1 and stay in IDLE.
- **C_DATA.**
  - fetch_valid=1.
  - fetch_data is registered from mem_dout using byte lane faddr[1:0]: 0 selects [7:0], 1 selects [15:8], 2 selects [23:16], 3 selects [31:24].
  - mem_csb=1; go to IDLE.
- **W_RDATA.** Register mem_dout into wbs_dat_o; mem_csb=1; go to W_ACK.
- **W_ACK.**
  - wbs_ack_o=1 and mem_csb=1.
  - wbs_dat_o holds the captured read data; it is unchanged on writes.
  - Go to IDLE.
- **Idle outputs.** Outside a granted IDLE cycle: mem_csb=1, mem_web=1, mem_wmask=0. mem_addr and mem_din are don't-care.
- **Arbitration timing.** A fetch_req arriving during any state is latched and served at the next IDLE.
- **Reset.** Asynchronous assertion at any time:
  - State returns to IDLE.
  - fetch_pend=0, starve_cnt=0.
  - No fetch_valid and no wbs_ack_o are issued for the interrupted transaction.
  - An SRAM write already issued may or may not have completed.

## Timing
- **Reset values.** fetch_valid=0, fetch_data=0, wbs_ack_o=0, wbs_dat_o=0, mem_csb=1, mem_web=1, mem_wmask=0, mem_addr=0, mem_din=0.
- **Fetch latency.** fetch_req at cycle T gives fetch_valid at T+2 when uncontended.
  - Minimum spacing between fetches is 2 cycles (IDLE then C_DATA).
- **Wishbone write.** Issued in IDLE cycle T; ack at T+1.
- **Wishbone read.** Issued at T; data captured at T+1; ack with data at T+2.
- **Wishbone master.** Holds cyc, stb, we, adr, dat and sel stable until it sees ack. It deasserts stb or starts a new cycle at the edge that samples ack.
- **Worst-case Wishbone wait.** STARVE_LIMIT core fetches × 2 cycles, plus the Wishbone service time.
- **Core fetch wait.** Bounded by one Wishbone transaction (at most 3 cycles).

## Test plan
- **Basic fetch.** Write word 0x44332211 at word 5. Pulse fetch_req with addr 0x016 → fetch_valid two cycles later with fetch_data=0x33.
- **Masked write readback.** Word 7 holds 0xFFFFFFFF. Wishbone write adr 0x1001C, dat 0xA5A5A5A5, sel 0b0101 → ack at T+1. Readback → ack at T+2 with dat_o=0xFFA5FFA5.
- **Starvation guard.** STARVE_LIMIT=4; hold a Wishbone read pending while pulsing fetch_req every 2 cycles → exactly 4 fetch_valid pulses, then a Wishbone ack, then fetches resume. starve_cnt returns to 0.
- **Simultaneous request.** fetch_req and a Wishbone write arrive in the same cycle with starve_cnt=0 → core is served first (fetch_valid at T+2). The Wishbone write issues in the next IDLE and is acked 1 cycle later.
- **Duplicate and foreign requests.** A second fetch_req while pending with a different address → only one fetch_valid, carrying the original byte. A Wishbone access with adr[16]=0 → no ack for 20 cycles and mem_csb stays 1.
- **Reset mid-operation.** Assert wb_rst_n low during W_RDATA → all outputs go to reset values immediately. No ack is issued after release. A new fetch completes normally.
